// File: rtl/uart_pkg.sv
// uart_pkg: parity mode codes, receiver FSM state codes and the 2-of-3 bit vote
package uart_pkg;
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_PAR   = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: one-cycle oversampling tick every div clocks; div=0 freezes it
module uart_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   logic [DIV_W-1:0] cnt;

   assign tick = (div != '0) && (cnt <= DIV_W'(1));

   // Count down to 1, then reload; a new divisor is picked up only at reload
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (tick) cnt <= div;
      else if (div != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority vote and valid/ready output
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int OVS       = 16,
   parameter int DIV_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 break_det,
   output logic                 overrun,
   input  logic                 overrun_clr
);
   localparam int PW = $clog2(OVS);
   localparam logic [PW-1:0] PH_A   = PW'(OVS / 2 - 1);
   localparam logic [PW-1:0] PH_B   = PW'(OVS / 2);
   localparam logic [PW-1:0] PH_C   = PW'(OVS / 2 + 1);
   localparam logic [PW-1:0] PH_END = PW'(OVS - 1);
   localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic [3:0] IDLE_BITS = 4'(DATA_BITS + 1);
   localparam bit HAS_PAR = (PARITY != PAR_NONE);

   logic [1:0]           sync;
   logic                 rxs, tick, en, bit_v, dec, bit_end, par_x, pe_w, brk;
   logic [2:0]           state;
   logic [PW-1:0]        phase;
   logic [3:0]           bitcnt;
   logic [1:0]           smp;
   logic [DATA_BITS-1:0] sh;
   logic                 par_bit, armed, done, d_fe, d_pe, d_bk;

   assign rxs     = sync[1];
   assign en      = (baud_div != '0);
   assign bit_v   = maj3({rxs, smp});
   assign dec     = tick && (phase == PH_C);
   assign bit_end = tick && (phase == PH_END);
   assign par_x   = ^sh ^ par_bit;
   assign pe_w    = HAS_PAR && ((PARITY == PAR_EVEN) ? par_x : !par_x);
   assign brk     = (sh == '0) && !par_bit && !bit_v;

   uart_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .div   (baud_div),
      .tick  (tick)
   );

   // Two-flop synchroniser; resets to the idle level
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= 2'b11;
      else sync <= {sync[0], rxd};

   // Frame FSM. While unarmed (after reset or a break) IDLE reuses phase/bitcnt
   // to demand a frame's worth of continuous high line before hunting again,
   // so the tail of an interrupted frame cannot be mistaken for a start bit.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= ST_IDLE;
         phase   <= '0;
         bitcnt  <= '0;
         smp     <= '0;
         sh      <= '0;
         par_bit <= 1'b0;
         armed   <= 1'b0;
         done    <= 1'b0;
         d_fe    <= 1'b0;
         d_pe    <= 1'b0;
         d_bk    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!en) state <= ST_IDLE;
         else if (tick) begin
            phase <= phase + 1'b1;
            if (phase == PH_A) smp[0] <= rxs;
            if (phase == PH_B) smp[1] <= rxs;
            case (state)
               ST_START:
                  if (dec && bit_v) state <= ST_IDLE;
                  else if (bit_end) state <= ST_DATA;
               ST_DATA: begin
                  if (dec) sh <= {bit_v, sh[DATA_BITS-1:1]};
                  if (bit_end) begin
                     bitcnt <= bitcnt + 1'b1;
                     if (bitcnt == LAST_BIT) state <= HAS_PAR ? ST_PAR : ST_STOP;
                  end
               end
               ST_PAR: begin
                  if (dec) par_bit <= bit_v;
                  if (bit_end) state <= ST_STOP;
               end
               ST_STOP:
                  if (dec) begin
                     state  <= ST_IDLE;
                     phase  <= '0;
                     bitcnt <= '0;
                     done   <= 1'b1;
                     d_fe   <= !bit_v;
                     d_pe   <= pe_w;
                     d_bk   <= brk;
                     armed  <= !brk;
                  end
               default: begin
                  state <= ST_IDLE;
                  if (!rxs) begin
                     phase  <= '0;
                     bitcnt <= '0;
                     if (armed) state <= ST_START;
                  end else if (!armed && phase == PH_END) begin
                     bitcnt <= bitcnt + 1'b1;
                     armed  <= (bitcnt == IDLE_BITS);
                  end
               end
            endcase
         end
      end

   // Holding register: load when empty or being drained, otherwise drop and flag overrun
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         break_det  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (done && (!rx_valid || rx_ready)) begin
            rx_data    <= sh;
            rx_valid   <= 1'b1;
            frame_err  <= d_fe;
            parity_err <= d_pe;
            break_det  <= d_bk;
         end else if (en && rx_valid && rx_ready) rx_valid <= 1'b0;
         overrun <= (done && rx_valid && !rx_ready) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
      end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of 8N1 and 8E1 receivers at 112 clk per bit
module tb_uart_rx_param;
   localparam int BIT = 112;

   logic        clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, rxd_p = 1'b1;
   logic        rx_ready = 1'b1, overrun_clr = 1'b0;
   logic [15:0] baud_div = 16'd7;
   logic [7:0]  rx_data, rx_data_p;
   logic        rx_valid, frame_err, parity_err, break_det, overrun;
   logic        rx_valid_p, frame_err_p, parity_err_p, break_det_p, overrun_p;
   int          total = 0, bad = 0, n_hs = 0, n_hs_p = 0;
   logic [7:0]  cap_d = '0, cap_d_p = '0;
   logic        cap_fe = 1'b0, cap_pe = 1'b0, cap_bk = 1'b0, cap_pe_p = 1'b0;

   always #5 clk = ~clk;

   uart_rx_param dut (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rxd(rxd),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .parity_err(parity_err), .break_det(break_det),
      .overrun(overrun), .overrun_clr(overrun_clr)
   );

   uart_rx_param #(.PARITY(1)) dut_p (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rxd(rxd_p),
      .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready),
      .frame_err(frame_err_p), .parity_err(parity_err_p), .break_det(break_det_p),
      .overrun(overrun_p), .overrun_clr(overrun_clr)
   );

   // Record every valid/ready handshake of both receivers
   always @(negedge clk) begin
      if (rx_valid && rx_ready) begin
         n_hs   <= n_hs + 1;
         cap_d  <= rx_data;
         cap_fe <= frame_err;
         cap_pe <= parity_err;
         cap_bk <= break_det;
      end
      if (rx_valid_p && rx_ready) begin
         n_hs_p   <= n_hs_p + 1;
         cap_d_p  <= rx_data_p;
         cap_pe_p <= parity_err_p;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic line(input bit to_p, input logic v, input int n);
      if (to_p) rxd_p = v;
      else rxd = v;
      clks(n);
   endtask

   task automatic send(input bit to_p, input logic [7:0] d, input bit has_par, input bit pbit);
      line(to_p, 1'b0, BIT);
      for (int i = 0; i < 8; i++) line(to_p, d[i], BIT);
      if (has_par) line(to_p, pbit, BIT);
      line(to_p, 1'b1, BIT);
   endtask

   initial begin
      logic [7:0] v5a;
      v5a = 8'h5A;
      clks(5);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_brk", break_det, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_valid_p", rx_valid_p, 0);
      rst_n = 1'b1;
      clks(12 * BIT);

      send(0, 8'hA5, 0, 0);
      chk("a5_count", n_hs, 1);
      chk("a5_data", cap_d, 8'hA5);
      chk("a5_ferr", cap_fe, 0);
      chk("a5_perr", cap_pe, 0);
      chk("a5_brk", cap_bk, 0);
      clks(2 * BIT);
      chk("a5_single", n_hs, 1);

      send(1, 8'h07, 1, 0);
      chk("par_bad_count", n_hs_p, 1);
      chk("par_bad_data", cap_d_p, 8'h07);
      chk("par_bad_perr", cap_pe_p, 1);
      clks(2 * BIT);
      send(1, 8'h07, 1, 1);
      chk("par_ok_count", n_hs_p, 2);
      chk("par_ok_data", cap_d_p, 8'h07);
      chk("par_ok_perr", cap_pe_p, 0);

      rxd = 1'b0;
      clks(40);
      rxd = 1'b1;
      clks(3 * BIT);
      chk("glitch_none", n_hs, 1);
      send(0, 8'h3C, 0, 0);
      chk("3c_count", n_hs, 2);
      chk("3c_data", cap_d, 8'h3C);
      chk("3c_ferr", cap_fe, 0);
      clks(2 * BIT);

      rx_ready = 1'b0;
      send(0, 8'h11, 0, 0);
      clks(BIT);
      send(0, 8'h22, 0, 0);
      clks(BIT);
      chk("ovr_valid", rx_valid, 1);
      chk("ovr_data", rx_data, 8'h11);
      chk("ovr_flag", overrun, 1);
      overrun_clr = 1'b1;
      clks(1);
      overrun_clr = 1'b0;
      chk("ovr_clr", overrun, 0);
      chk("ovr_hold_valid", rx_valid, 1);
      chk("ovr_hold_data", rx_data, 8'h11);
      rx_ready = 1'b1;
      clks(2);
      chk("ovr_drain_count", n_hs, 3);
      chk("ovr_drain_data", cap_d, 8'h11);
      chk("ovr_drain_valid", rx_valid, 0);

      rxd = 1'b0;
      clks(12 * BIT);
      rxd = 1'b1;
      clks(3 * BIT);
      chk("brk_count", n_hs, 4);
      chk("brk_data", cap_d, 8'h00);
      chk("brk_ferr", cap_fe, 1);
      chk("brk_flag", cap_bk, 1);
      clks(10 * BIT);

      line(0, 1'b0, BIT);
      for (int i = 0; i < 4; i++) line(0, v5a[i], BIT);
      line(0, v5a[4], BIT / 2);
      rst_n = 1'b0;
      clks(3);
      chk("midrst_valid", rx_valid, 0);
      rst_n = 1'b1;
      clks(BIT / 2 - 3);
      for (int i = 5; i < 8; i++) line(0, v5a[i], BIT);
      line(0, 1'b1, BIT);
      chk("midrst_drop", n_hs, 4);
      clks(12 * BIT);
      chk("midrst_quiet", n_hs, 4);
      send(0, 8'h5A, 0, 0);
      clks(2 * BIT);
      chk("5a_count", n_hs, 5);
      chk("5a_data", cap_d, 8'h5A);
      chk("5a_ferr", cap_fe, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter OVS, default 16, meaning oversampling ticks per bit (power of 2, 8..32).
REQ-004 SHALL have parameter DIV_W, default 16, meaning width of the runtime divisor.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port baud_div, input, DIV_W, meaning clk cycles per oversampling tick; 0 disables the receiver.
REQ-008 SHALL have port rxd, input, 1, meaning the asynchronous serial line (idle high).
REQ-009 SHALL have port rx_data, output, DATA_BITS, meaning the received word, LSB first on the line.
REQ-010 SHALL have port rx_valid, output, 1, meaning rx_data and the error flags hold a frame.
REQ-011 SHALL have port rx_ready, input, 1, meaning the consumer accepts the frame when high together with rx_valid.
REQ-012 SHALL have port frame_err, output, 1, meaning the first stop bit sampled low (qualified by rx_valid).
REQ-013 SHALL have port parity_err, output, 1, meaning parity mismatch (qualified by rx_valid; always 0 when PARITY=0).
REQ-014 SHALL have port break_det, output, 1, meaning all data bits, parity and stop sampled 0 (qualified by rx_valid).
REQ-015 SHALL have port overrun, output, 1, meaning sticky flag: a frame was lost; cleared by overrun_clr.
REQ-016 SHALL have port overrun_clr, input, 1, meaning a one-cycle clear of overrun.

Function
REQ-017 SHALL resynchronise rxd through a 2-flop synchroniser on every clk.
REQ-018 SHALL generate a one-cycle tick every baud_div clk cycles from a down-counter that reloads from baud_div; a baud_div change takes effect at the next reload.
REQ-019 SHALL, with baud_div=0, hold the FSM in IDLE, stop the tick counter, and keep rx_valid/rx_data unchanged.
REQ-020 SHALL run FSM states IDLE, START, DATA, PAR, STOP; PAR is skipped when PARITY=0.
REQ-021 SHALL leave IDLE for START on the first tick seeing synchronised rxd=0, clearing the tick-phase counter to 0.
REQ-022 SHALL decide each bit by a 2-of-3 majority of samples at tick phases OVS/2-1, OVS/2 and OVS/2+1.
REQ-023 SHALL return from START to IDLE without output if the start-bit majority is 1 (glitch rejection).
REQ-024 SHALL shift DATA_BITS bits LSB-first in DATA, advancing one bit every OVS ticks.
REQ-025 SHALL compute parity as the XOR of the data bits and the parity bit; an error is a result of 1 for even and 0 for odd.
REQ-026 SHALL, at the STOP decision (phase OVS/2+1), update outputs on the next clk, then return to IDLE; a low stop bit does not delay the return (hunt resumes immediately).
REQ-027 SHALL load rx_data and the flags and set rx_valid when rx_valid is 0, or rx_valid and rx_ready are both 1 in that same cycle.
REQ-028 SHALL, when a frame completes while rx_valid=1 and rx_ready=0, discard the new frame, keep the held frame, and set overrun.
REQ-029 SHALL clear rx_valid the cycle after a rx_valid&&rx_ready handshake unless a new frame loads in that cycle.
REQ-030 SHALL hold rx_data and the flags stable while rx_valid=1 and no handshake occurs.
REQ-031 SHALL give overrun set priority over overrun_clr when both occur in one cycle.
REQ-032 SHALL report exactly one frame per start bit; the receiver never asserts rx_valid twice for one frame.

Reset
REQ-033 SHALL, on rst_n low, asynchronously force FSM to IDLE, synchroniser flops to 1, the counters to 0, rx_data to 0, and rx_valid, frame_err, parity_err, break_det and overrun to 0.
REQ-034 SHALL, if reset lands mid-frame, discard the partial frame and resume hunting for a start bit only after rxd is seen high.

Structure
REQ-035 SHALL take the parity-mode encodings (NONE/EVEN/ODD) and the FSM state enumeration from a shared package, uart_pkg.
REQ-036 SHALL place the divisor/tick counter in a sub-module, uart_tick_gen, with ports clk, rst_n, div, tick.

Verification
REQ-037 SHALL cover this case: baud_div=7, OVS=16, 8N1, byte 0xA5 sent at 112 clk/bit -> rx_data=0xA5, rx_valid 1 cycle after mid-stop, flags 0.
REQ-038 SHALL cover this case: PARITY=1, byte 0x07 with a wrong parity bit of 0 -> rx_data=0x07, parity_err=1; with parity bit 1 -> parity_err=0.
REQ-039 SHALL cover this case: a low pulse of 40 clk on rxd in IDLE -> no rx_valid; a following 0x3C frame is received correctly.
REQ-040 SHALL cover this case: rx_ready held 0 across bytes 0x11 and 0x22 -> rx_data stays 0x11, overrun=1; overrun_clr with no new frame -> overrun=0.
REQ-041 SHALL cover this case: rxd held low for 12 bit times, then high -> one rx_valid with rx_data=0x00, frame_err=1, break_det=1.
REQ-042 SHALL cover this case: rst_n pulsed low during bit 4 of 0x5A, then a clean 0x5A sent -> the partial frame is dropped and one rx_valid with 0x5A is reported.
